// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// 8N1 UART receive path. RxD is brought into the clk domain through a two-flop
// synchronizer, sampled with OVERSAMPLE ticks per bit, and checked for a valid
// start bit (mid-bit low) and stop bit (mid-bit high). Each good byte is
// presented on `data` with a one-clock `data_valid` strobe; a low stop bit
// raises a one-clock `framing_error` instead, and the receiver then waits for
// the line to return high so a held-low break is not decoded as 0x00 frames.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bits/s (must match the transmitter)
//   OVERSAMPLE  sample ticks per bit; even and at least 8
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   RxD            asynchronous serial input, idles high
//   data           last correctly received byte
//   data_valid     one-clock pulse when data updates
//   framing_error  one-clock pulse when the stop bit is sampled low
//   busy           high while a frame is in progress (any state but IDLE)
// -----------------------------------------------------------------------------
module uart_receiver #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RxD,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       framing_error,
   output logic       busy
);

   // Clock cycles per oversample tick, truncated (651 at the defaults).
   localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW       = $clog2(OVERSAMPLE);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic          r_sync1;
   logic          r_sync2;       // rx_s: the only copy of the line used below
   state_t        r_state;
   logic [TW-1:0] r_tick_cnt;
   logic [SW-1:0] r_samp_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_data_valid;
   logic          r_framing_error;

   // ---------------------------------------------------------------------------
   // Next-state / control wires
   // ---------------------------------------------------------------------------
   state_t w_next_state;
   logic   w_tick;
   logic   w_tick_clr;
   logic   w_samp_clr;
   logic   w_samp_inc;
   logic   w_bit_clr;
   logic   w_bit_inc;
   logic   w_shift_en;
   logic   w_load;
   logic   w_fe;

   assign w_tick = (r_tick_cnt == TICK_LAST);

   // ---------------------------------------------------------------------------
   // Input synchronizer. Both flops reset to the idle level so a reset never
   // looks like a start bit.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is always written with non-blocking (<=) so every
   // flop samples the pre-edge value of its source; with blocking (=) the
   // second synchronizer stage would collapse into the first.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RxD;
         r_sync2 <= r_sync1;
      end
   end

   // ---------------------------------------------------------------------------
   // Oversample tick generator. Free-running, but restarted on the detected
   // falling edge so every later mid-bit sample is measured from that edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick_cnt <= '0;
      end else if (w_tick_clr || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and control decode. The line is looked at only on the
   // mid-bit ticks (and continuously in IDLE / WAIT_HIGH, where we are
   // waiting for a level change).
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before the case statement;
   // a path that left one unassigned would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_tick_clr   = 1'b0;
      w_samp_clr   = 1'b0;
      w_samp_inc   = 1'b0;
      w_bit_clr    = 1'b0;
      w_bit_inc    = 1'b0;
      w_shift_en   = 1'b0;
      w_load       = 1'b0;
      w_fe         = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (!r_sync2) begin
               w_next_state = S_START;
               w_tick_clr   = 1'b1;
               w_samp_clr   = 1'b1;
            end
         end

         S_START: begin
            if (w_tick) begin
               if (r_samp_cnt == SAMP_MID) begin
                  if (!r_sync2) begin
                     w_next_state = S_DATA;
                     w_samp_clr   = 1'b1;
                     w_bit_clr    = 1'b1;
                  end else begin
                     // Line went back high before mid start bit: a glitch.
                     w_next_state = S_IDLE;
                  end
               end else begin
                  w_samp_inc = 1'b1;
               end
            end
         end

         S_DATA: begin
            if (w_tick) begin
               if (r_samp_cnt == SAMP_LAST) begin
                  w_shift_en = 1'b1;
                  w_samp_clr = 1'b1;
                  if (r_bit_cnt == 3'd7) begin
                     w_next_state = S_STOP;
                  end else begin
                     w_bit_inc = 1'b1;
                  end
               end else begin
                  w_samp_inc = 1'b1;
               end
            end
         end

         S_STOP: begin
            if (w_tick) begin
               if (r_samp_cnt == SAMP_LAST) begin
                  if (r_sync2) begin
                     w_load       = 1'b1;
                     w_next_state = S_IDLE;
                  end else begin
                     w_fe         = 1'b1;
                     w_next_state = S_WAIT_HIGH;
                  end
               end else begin
                  w_samp_inc = 1'b1;
               end
            end
         end

         S_WAIT_HIGH: begin
            // Hold off until the line recovers so a break is not read as
            // a stream of 0x00 frames.
            if (r_sync2) begin
               w_next_state = S_IDLE;
            end
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sample and bit counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_samp_cnt <= '0;
         r_bit_cnt  <= '0;
      end else begin
         if (w_samp_clr) begin
            r_samp_cnt <= '0;
         end else if (w_samp_inc) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
         end

         if (w_bit_clr) begin
            r_bit_cnt <= '0;
         end else if (w_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Data path: LSB-first shift register, output byte and status pulses.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift         <= '0;
         r_data          <= '0;
         r_data_valid    <= 1'b0;
         r_framing_error <= 1'b0;
      end else begin
         if (w_shift_en) begin
            r_shift <= {r_sync2, r_shift[7:1]};
         end
         if (w_load) begin
            r_data <= r_shift;
         end
         // w_load and w_fe come from exclusive branches of STOP, so these
         // two pulses can never coincide.
         r_data_valid    <= w_load;
         r_framing_error <= w_fe;
      end
   end

   assign data          = r_data;
   assign data_valid    = r_data_valid;
   assign framing_error = r_framing_error;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed plus randomized bench for uart_receiver. The receiver is run at a
// reduced CLK_FREQ / BAUD ratio (10 clk per tick, 160 clk per bit) so every
// scenario fits in a short run. The reference model is a queue of the bytes
// the bench framed with a high stop bit: each must appear once, in order, on
// data_valid; anything else must produce no data_valid.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

   localparam int CLK_FREQ = 1_700_000;
   localparam int BAUD     = 10_000;
   localparam int OS       = 16;
   localparam int TD       = CLK_FREQ / (BAUD * OS);   // 10 (truncated)
   localparam int BIT      = TD * OS;                  // clk per bit

   logic       clk = 1'b0;
   logic       reset;
   logic       RxD;
   logic [7:0] data;
   logic       data_valid;
   logic       framing_error;
   logic       busy;

   always #5 clk = ~clk;

   uart_receiver #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .OVERSAMPLE(OS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .RxD          (RxD),
      .data         (data),
      .data_valid   (data_valid),
      .framing_error(framing_error),
      .busy         (busy)
   );

   // ---------------------------------------------------------------------------
   // Cycle counter and output monitor (sampled on the falling edge).
   // ---------------------------------------------------------------------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] got_q[$];
   int   dv_cnt        = 0;
   int   fe_cnt        = 0;
   int   both_cnt      = 0;
   int   stretch_cnt   = 0;
   int   busy_fall_cnt = 0;
   int   last_dv_cyc   = 0;
   logic prev_dv       = 1'b0;
   logic prev_fe       = 1'b0;
   logic prev_busy     = 1'b0;

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         got_q.push_back(data);
         dv_cnt      <= dv_cnt + 1;
         last_dv_cyc <= cyc;
      end
      if (framing_error === 1'b1) fe_cnt <= fe_cnt + 1;
      if (data_valid === 1'b1 && framing_error === 1'b1) both_cnt <= both_cnt + 1;
      if ((prev_dv === 1'b1 && data_valid === 1'b1) ||
          (prev_fe === 1'b1 && framing_error === 1'b1)) stretch_cnt <= stretch_cnt + 1;
      if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cnt <= busy_fall_cnt + 1;
      prev_dv   <= data_valid;
      prev_fe   <= framing_error;
      prev_busy <= busy;
   end

   // ---------------------------------------------------------------------------
   // Checking and stimulus helpers
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at #1 after a posedge; holds the level for n clocks and returns at
   // #1 after a posedge again, so all drives stay aligned.
   task automatic drive_bit(input logic b, input int n);
      RxD = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_level);
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
      drive_bit(stop_level, BIT);
   endtask

   logic [7:0] exp_q[$];   // reference model: bytes that must be delivered

   // ---------------------------------------------------------------------------
   // Directed and random sequence
   // ---------------------------------------------------------------------------
   initial begin
      int dv0, fe0, bf0, t_fall, gap;
      logic [7:0] b;

      reset = 1'b1;
      RxD   = 1'b1;

      // Reset values
      repeat (5) @(posedge clk);
      #1;
      check("rst_data",  32'(data),          32'h00);
      check("rst_dv",    32'(data_valid),    32'h0);
      check("rst_fe",    32'(framing_error), 32'h0);
      check("rst_busy",  32'(busy),          32'h0);
      reset = 1'b0;
      drive_bit(1'b1, BIT);
      check("idle_busy", 32'(busy), 32'h0);

      // Single byte 0xA5 and latency from the falling edge
      dv0 = dv_cnt; fe0 = fe_cnt; t_fall = cyc;
      send_frame(8'hA5, 1'b1);
      exp_q.push_back(8'hA5);
      drive_bit(1'b1, 20);
      check("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
      check("a5_fe_count", 32'(fe_cnt - fe0), 32'd0);
      check("a5_data",     32'(data),         32'hA5);
      check("a5_latency",  32'(last_dv_cyc - t_fall), 32'((19 * BIT) / 2 + 3));
      check("a5_busy",     32'(busy),         32'h0);

      // Back-to-back 0x00 then 0xFF, no idle between frames
      dv0 = dv_cnt; bf0 = busy_fall_cnt;
      send_frame(8'h00, 1'b1);
      exp_q.push_back(8'h00);
      check("b2b_first_dv",   32'(dv_cnt - dv0), 32'd1);
      check("b2b_first_data", 32'(data),         32'h00);
      send_frame(8'hFF, 1'b1);
      exp_q.push_back(8'hFF);
      drive_bit(1'b1, 20);
      check("b2b_dv_count",  32'(dv_cnt - dv0),        32'd2);
      check("b2b_data",      32'(data),                32'hFF);
      check("b2b_busy_fall", 32'(busy_fall_cnt - bf0), 32'd2);

      // Glitch shorter than half a bit, then a real frame
      dv0 = dv_cnt; fe0 = fe_cnt;
      drive_bit(1'b0, BIT / 2 - 20);
      drive_bit(1'b1, BIT);
      check("glitch_dv",   32'(dv_cnt - dv0), 32'd0);
      check("glitch_fe",   32'(fe_cnt - fe0), 32'd0);
      check("glitch_busy", 32'(busy),         32'h0);
      send_frame(8'h3C, 1'b1);
      exp_q.push_back(8'h3C);
      drive_bit(1'b1, 20);
      check("glitch_next_data", 32'(data), 32'h3C);

      // Framing error after a good byte; line held low for three bit periods
      send_frame(8'h12, 1'b1);
      exp_q.push_back(8'h12);
      drive_bit(1'b1, BIT);
      dv0 = dv_cnt; fe0 = fe_cnt;
      drive_bit(1'b0, BIT);
      b = 8'h55;
      for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
      drive_bit(1'b0, 3 * BIT);
      check("fe_count",     32'(fe_cnt - fe0), 32'd1);
      check("fe_dv",        32'(dv_cnt - dv0), 32'd0);
      check("fe_data_held", 32'(data),         32'h12);
      check("fe_busy_low",  32'(busy),         32'h1);
      drive_bit(1'b1, BIT);
      check("fe_busy_rel",  32'(busy),         32'h0);
      check("fe_dv_after",  32'(dv_cnt - dv0), 32'd0);
      send_frame(8'h81, 1'b1);
      exp_q.push_back(8'h81);
      drive_bit(1'b1, 20);
      check("fe_next_data", 32'(data), 32'h81);

      // Reset during bit 3 of a 0xF0 frame
      dv0 = dv_cnt; fe0 = fe_cnt;
      b = 8'hF0;
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 3; i++) drive_bit(b[i], BIT);
      drive_bit(b[3], BIT / 2);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      drive_bit(1'b1, 2 * BIT);
      check("rstmid_dv",   32'(dv_cnt - dv0), 32'd0);
      check("rstmid_fe",   32'(fe_cnt - fe0), 32'd0);
      check("rstmid_busy", 32'(busy),         32'h0);
      check("rstmid_data", 32'(data),         32'h00);
      send_frame(8'h7E, 1'b1);
      exp_q.push_back(8'h7E);
      drive_bit(1'b1, 20);
      check("rstmid_next_data", 32'(data), 32'h7E);

      // Random bytes with random idle gaps (including none)
      for (int k = 0; k < 6; k++) begin
         b   = 8'($urandom);
         gap = int'($urandom_range(0, BIT));
         send_frame(b, 1'b1);
         exp_q.push_back(b);
         if (gap > 0) drive_bit(1'b1, gap);
      end
      drive_bit(1'b1, BIT);

      // Scoreboard against the reference queue
      check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         check("sb_byte", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      end
      check("pulse_overlap", 32'(both_cnt),    32'd0);
      check("pulse_stretch", 32'(stretch_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
